// File: rtl/sort_frame_ctrl.sv
// Frame sequencer for the N-slot systolic insertion sorter: clear, load LEN
// pairs from a valid/ready stream, settle, then drain the sorted slots in order.
module sort_frame_ctrl #(
    parameter int N  = 64,
    parameter int CW = $clog2(N + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [CW-1:0]   cfg_len,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [7:0]      in_data,
    input  logic [7:0]      in_addr,
    output logic            sorter_clr,
    output logic            sorter_en,
    output logic [7:0]      sorter_data,
    output logic [7:0]      sorter_addr,
    input  logic [N*8-1:0]  sorted_data,
    input  logic [N*8-1:0]  sorted_addr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_data,
    output logic [7:0]      out_addr,
    output logic            out_last,
    output logic            busy,
    output logic            done
);

    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, SETTLE, DRAIN} state_t;

    localparam int            SLOTS = 1 << CW;
    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [CW-1:0] N_LEN = CW'(N);

    state_t        state, state_d;
    logic [CW-1:0] len, len_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [CW-1:0] idx, idx_d;
    logic          done_q, done_d;
    logic [CW-1:0] cfg_clamped;

    // Slot views padded to a power of two so idx can index them at full width.
    logic [7:0] slot_data [SLOTS];
    logic [7:0] slot_addr [SLOTS];

    for (genvar g = 0; g < SLOTS; g++) begin : g_slot
        if (g < N) begin : g_real
            assign slot_data[g] = sorted_data[8*g +: 8];
            assign slot_addr[g] = sorted_addr[8*g +: 8];
        end else begin : g_pad
            assign slot_data[g] = '0;
            assign slot_addr[g] = '0;
        end
    end

    assign cfg_clamped = (cfg_len > N_LEN) ? N_LEN : cfg_len;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            len    <= '0;
            cnt    <= '0;
            idx    <= '0;
            done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register here samples pre-edge values.
            state  <= state_d;
            len    <= len_d;
            cnt    <= cnt_d;
            idx    <= idx_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latches).
        state_d    = state;
        len_d      = len;
        cnt_d      = cnt;
        idx_d      = idx;
        done_d     = 1'b0;
        in_ready   = 1'b0;
        sorter_clr = 1'b0;
        sorter_en  = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;

        case (state)
            IDLE: begin
                // A start coinciding with the done pulse belongs to the old frame.
                if (start && !done_q) begin
                    len_d = cfg_clamped;
                    if (cfg_clamped == '0) done_d  = 1'b1;
                    else                   state_d = CLEAR;
                end
            end
            CLEAR: begin
                sorter_clr = 1'b1;
                cnt_d      = '0;
                state_d    = LOAD;
            end
            LOAD: begin
                in_ready  = 1'b1;
                sorter_en = in_valid;
                if (in_valid) begin
                    cnt_d = cnt + ONE;
                    if (cnt == len - ONE) state_d = SETTLE;
                end
            end
            SETTLE: begin
                // Gives the ICG one enable-free cycle so sorted_* is stable in DRAIN.
                idx_d   = '0;
                state_d = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_last  = (idx == len - ONE);
                if (out_ready) begin
                    idx_d = idx + ONE;
                    if (out_last) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sorter_data = (state == LOAD)  ? in_data        : '0;
    assign sorter_addr = (state == LOAD)  ? in_addr        : '0;
    assign out_data    = (state == DRAIN) ? slot_data[idx] : '0;
    assign out_addr    = (state == DRAIN) ? slot_addr[idx] : '0;
    assign busy        = (state != IDLE);
    assign done        = done_q;

endmodule

// File: tb/tb_sort_frame_ctrl.sv
// Scoreboard bench for sort_frame_ctrl with a behavioural insertion sorter (N=8).
module tb_sort_frame_ctrl;

    localparam int N  = 8;
    localparam int CW = $clog2(N + 1);

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic [CW-1:0]   cfg_len = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [7:0]      in_data = 8'h00;
    logic [7:0]      in_addr = 8'h00;
    logic            sorter_clr, sorter_en;
    logic [7:0]      sorter_data, sorter_addr;
    logic [N*8-1:0]  sorted_data, sorted_addr;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [7:0]      out_data, out_addr;
    logic            out_last, busy, done;

    sort_frame_ctrl #(.N(N), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_addr(in_addr),
        .sorter_clr(sorter_clr), .sorter_en(sorter_en),
        .sorter_data(sorter_data), .sorter_addr(sorter_addr),
        .sorted_data(sorted_data), .sorted_addr(sorted_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Behavioural sorter: descending from slot 0, later equal values land higher.
    logic [7:0] sv [N];
    logic [7:0] sa [N];
    initial for (int i = 0; i < N; i++) begin sv[i] = 8'h00; sa[i] = 8'h00; end

    always @(posedge clk) begin
        if (sorter_clr) begin
            for (int i = 0; i < N; i++) begin sv[i] <= 8'h00; sa[i] <= 8'h00; end
        end else if (sorter_en) begin
            automatic int pos = N;
            for (int i = 0; i < N; i++)
                if (pos == N && sorter_data >= sv[i]) pos = i;
            for (int i = N - 1; i > pos; i--) begin sv[i] <= sv[i-1]; sa[i] <= sa[i-1]; end
            if (pos < N) begin sv[pos] <= sorter_data; sa[pos] <= sorter_addr; end
        end
    end

    always_comb begin
        sorted_data = '0;
        sorted_addr = '0;
        for (int i = 0; i < N; i++) begin
            sorted_data[8*i +: 8] = sv[i];
            sorted_addr[8*i +: 8] = sa[i];
        end
    end

    typedef struct packed {
        logic [7:0] d;
        logic [7:0] a;
        logic       last;
    } exp_t;

    exp_t       exp_q [$];
    logic [7:0] st_d [$];
    logic [7:0] st_a [$];

    int n_checks = 0;
    int n_err    = 0;
    int cyc = 0, en_cnt = 0, clr_cnt = 0, acc_cnt = 0, out_cnt = 0;
    int done_cnt = 0, busy_cnt = 0, done_cyc = 0, last_out_cyc = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            if (sorter_en)            en_cnt++;
            if (sorter_clr)           clr_cnt++;
            if (busy)                 busy_cnt++;
            if (in_valid && in_ready) acc_cnt++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (out_valid && out_ready) begin
                out_cnt++;
                if (out_last) last_out_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("sb_avail", exp_q.size(), 1);
                end else begin
                    automatic exp_t e = exp_q.pop_front();
                    check("out", {out_data, out_addr, out_last}, e);
                end
            end
        end
    end

    // Reference order: repeatedly take the maximum; ">=" makes later ties win.
    task automatic push_expected(input int len);
        logic used [16];
        for (int i = 0; i < 16; i++) used[i] = 1'b0;
        for (int o = 0; o < len; o++) begin
            automatic int best = -1;
            for (int i = 0; i < len; i++)
                if (!used[i] && (best < 0 || st_d[i] >= st_d[best])) best = i;
            used[best] = 1'b1;
            exp_q.push_back('{d: st_d[best], a: st_a[best], last: (o == len - 1)});
        end
    endtask

    task automatic start_frame(input int c);
        start   = 1'b1;
        cfg_len = CW'(c);
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    task automatic feed(input int n, input logic [31:0] pat, input int plen);
        int k = 0, p = 0, guard = 0;
        logic hs;
        while (k < n && guard < 200) begin
            in_valid = pat[p % plen];
            in_data  = st_d[k];
            in_addr  = st_a[k];
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            if (hs) k++;
            p++;
            guard++;
        end
        in_valid = 1'b0;
        if (k < n) check("feed_timeout", k, n);
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        int i  = 0;
        while (done_cnt == d0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        @(negedge clk);
        check("done_pulses", done_cnt - d0, 1);
        @(posedge clk); #1;
    endtask

    task automatic run_frame(input int cfg, input logic [31:0] pat, input int plen,
                             input int stall, input bit hold);
        int len = (cfg < N) ? cfg : N;
        int en0 = en_cnt, clr0 = clr_cnt, acc0 = acc_cnt, out0 = out_cnt;
        push_expected(len);
        out_ready = (stall == 0);
        start_frame(cfg);
        feed(len, pat, plen);
        check("in_ready_drop", in_ready, 0);
        if (hold) begin
            in_valid = 1'b1;
            in_data  = 8'hFF;
            in_addr  = 8'hEE;
        end
        if (stall > 0) begin
            logic [16:0] snap;
            int i = 0;
            while (!out_valid && i < 20) begin @(negedge clk); i++; end
            check("drain_start", out_valid, 1);
            snap = {out_data, out_addr, out_last};
            repeat (stall) begin
                @(negedge clk);
                check("stall_hold", {out_data, out_addr, out_last}, snap);
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
        end
        wait_done(100);
        in_valid = 1'b0;
        check("en_count",  en_cnt  - en0,  len);
        check("clr_count", clr_cnt - clr0, 1);
        check("acc_count", acc_cnt - acc0, len);
        check("out_count", out_cnt - out0, len);
        check("done_lat",  done_cyc - last_out_cyc, 1);
        check("sb_left",   exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, c0, b0;

        in_data = 8'h5A;
        in_addr = 8'hA5;
        #3;
        check("reset_outs", {in_ready, out_valid, out_last, sorter_clr, sorter_en, busy, done}, 0);
        #9 rst = 1'b1;
        @(posedge clk); #1;

        // Back-to-back load with a tie on 0x80.
        st_d = '{8'h10, 8'h80, 8'h40, 8'h80};
        st_a = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        run_frame(4, 32'h1, 1, 0, 1'b0);

        // Same frame with bubbles: valid pattern 1,0,0,1,0,1,1.
        run_frame(4, 32'b1101001, 7, 0, 1'b0);

        // Downstream stall during drain.
        st_d = '{8'h33, 8'h99, 8'h33};
        st_a = '{8'hB0, 8'hB1, 8'hB2};
        run_frame(3, 32'h1, 1, 5, 1'b0);

        // Zero-length frame; start held into the done cycle must be ignored.
        d0 = done_cnt; c0 = clr_cnt; b0 = busy_cnt;
        start   = 1'b1;
        cfg_len = '0;
        @(negedge clk);
        check("z_busy_start", busy, 0);
        @(posedge clk); #1;
        cfg_len = CW'(3);
        @(negedge clk);
        check("z_done", done, 1);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("z_start_ignored", busy, 0);
        @(negedge clk);
        check("z_done_once", done_cnt - d0, 1);
        check("z_no_clr", clr_cnt - c0, 0);
        check("z_busy_cnt", busy_cnt - b0, 0);
        @(posedge clk); #1;

        // Length clamp: cfg_len = N+5, valid held high past the frame.
        st_d = '{8'h21, 8'h07, 8'hC0, 8'h21, 8'h7F, 8'h00, 8'hC0, 8'h55};
        st_a = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        run_frame(N + 5, 32'h1, 1, 0, 1'b1);

        // Reset in the middle of LOAD after two of five elements.
        st_d = '{8'h90, 8'h91, 8'h92, 8'h93, 8'h94};
        st_a = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
        d0 = done_cnt;
        start_frame(5);
        feed(2, 32'h1, 1);
        in_valid = 1'b1;
        in_data  = 8'h55;
        in_addr  = 8'h66;
        #2 rst = 1'b0;
        #1;
        check("abort_outs", {in_ready, out_valid, out_last, sorter_clr, sorter_en, busy, done,
                             sorter_data, sorter_addr, out_data, out_addr}, 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        @(posedge clk); #1;

        st_d = '{8'h05, 8'h07};
        st_a = '{8'hD0, 8'hD1};
        run_frame(2, 32'h1, 1, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
